// File: rtl/accuracy_uart_pkg.sv
// Shared definitions for the accuracy UART reporter: session states, summary
// frame constants and the baud divider helper.
package accuracy_uart_pkg;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      SUMMARY = 2'd1,
      DRAIN   = 2'd2
   } state_t;

   localparam logic [7:0] SUMMARY_SYNC = 8'hA5;
   localparam int         SUMMARY_LEN  = 5;

   // Truncating divide: bit period in clock cycles.
   function automatic int baud_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter. Pops a byte whenever idle (or on the last cycle of a
// stop bit, so back-to-back frames have no gap) and drives a registered tx line.
module uart_tx_serializer #(
   parameter int DIV = 217
) (
   input  logic       clk_25m,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_pop,
   output logic       tx_busy,
   output logic       tx
);

   localparam int            DW       = $clog2(DIV + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   logic          active;
   logic [DW-1:0] div_cnt;
   logic [3:0]    bit_cnt;
   logic [8:0]    shift;
   logic          bit_end;
   logic          frame_end;

   assign bit_end   = (div_cnt == DIV_LAST);
   assign frame_end = active && bit_end && (bit_cnt == 4'd9);
   assign tx_pop    = tx_start && (!active || frame_end);
   assign tx_busy   = active;

   // bit_cnt: 0 = start, 1..8 = data, 9 = stop
   always_ff @(posedge clk_25m) begin
      if (rst) begin
         active  <= 1'b0;
         div_cnt <= '0;
         bit_cnt <= '0;
         tx      <= 1'b1;
      end else if (tx_pop) begin
         active  <= 1'b1;
         div_cnt <= '0;
         bit_cnt <= '0;
         tx      <= 1'b0;
      end else if (active) begin
         if (bit_end) begin
            div_cnt <= '0;
            if (bit_cnt == 4'd9) begin
               active <= 1'b0;
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
               tx      <= shift[0];
            end
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

   // Stop bit rides in at the top so the ninth shift presents it on tx.
   always_ff @(posedge clk_25m) begin
      if (tx_pop)
         shift <= {1'b1, tx_data};
      else if (active && bit_end && (bit_cnt != 4'd9))
         shift <= {1'b1, shift[8:1]};
   end

endmodule

// File: rtl/accuracy_uart_reporter.sv
// Accuracy session reporter: counts results vs labels, queues result bytes in a
// FIFO and streams them over UART. Define ACC_SUMMARY_EN to append a summary frame.
module accuracy_uart_reporter
   import accuracy_uart_pkg::*;
#(
   parameter int CLK_HZ      = 25000000,
   parameter int BAUD        = 115200,
   parameter int RESULT_W    = 4,
   parameter int NUM_SAMPLES = 100,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic                clk_25m,
   input  logic                rst,
   input  logic                uart_knob,
   input  logic                result_valid,
   input  logic [RESULT_W-1:0] result,
   input  logic [RESULT_W-1:0] label,
   input  logic                clear,
   output logic [15:0]         sample_count,
   output logic [15:0]         correct_count,
   output logic                overflow,
   output logic                busy,
   output logic                done,
   output logic                tx
);

   localparam int            DIV      = baud_div(CLK_HZ, BAUD);
   localparam int            AW       = $clog2(FIFO_DEPTH);
   localparam logic [15:0]   LAST_IDX = 16'(NUM_SAMPLES - 1);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

   state_t        state_q, state_d;
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   fifo_cnt;
   logic          accept, last_sample, full_eff;
   logic          push_req, push_ok, pop, tx_start, ser_busy;
   logic [7:0]    push_data;

`ifdef ACC_SUMMARY_EN
   logic [2:0] sum_idx;

   function automatic logic [7:0] summary_byte(input logic [2:0] idx,
                                               input logic [15:0] cc,
                                               input logic [15:0] sc);
      case (idx)
         3'd0:    return SUMMARY_SYNC;
         3'd1:    return cc[15:8];
         3'd2:    return cc[7:0];
         3'd3:    return sc[15:8];
         default: return sc[7:0];
      endcase
   endfunction
`endif

   assign accept      = result_valid && uart_knob && (state_q == COLLECT) && !clear;
   assign last_sample = accept && (sample_count == LAST_IDX);
   // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
   assign full_eff    = (fifo_cnt == FULL_CNT) && !pop;
   assign push_ok     = push_req && !full_eff;
   assign tx_start    = (fifo_cnt != '0) && !clear;
   assign busy        = (fifo_cnt != '0) || ser_busy;

   always_comb begin
      state_d   = state_q;
      push_req  = 1'b0;
      push_data = 8'(result);
      case (state_q)
         COLLECT: begin
            push_req = accept;
            if (last_sample) begin
`ifdef ACC_SUMMARY_EN
               state_d = SUMMARY;
`else
               state_d = DRAIN;
`endif
            end
         end
`ifdef ACC_SUMMARY_EN
         SUMMARY: begin
            push_req  = 1'b1;
            push_data = summary_byte(sum_idx, correct_count, sample_count);
            if (push_ok && (sum_idx == 3'(SUMMARY_LEN - 1)))
               state_d = DRAIN;
         end
`endif
         default: ;
      endcase
      if (clear) begin
         state_d  = COLLECT;
         push_req = 1'b0;
      end
   end

   always_ff @(posedge clk_25m) begin
      if (rst || clear) begin
         state_q       <= COLLECT;
         sample_count  <= '0;
         correct_count <= '0;
         overflow      <= 1'b0;
         done          <= 1'b0;
`ifdef ACC_SUMMARY_EN
         sum_idx       <= '0;
`endif
      end else begin
         state_q <= state_d;
         if (accept) begin
            sample_count <= sample_count + 16'd1;
            if (result == label)
               correct_count <= correct_count + 16'd1;
            if (full_eff)
               overflow <= 1'b1;
         end
`ifdef ACC_SUMMARY_EN
         if ((state_q == SUMMARY) && push_ok)
            sum_idx <= sum_idx + 3'd1;
`endif
         done <= (state_q == DRAIN) && (fifo_cnt == '0) && !ser_busy;
      end
   end

   always_ff @(posedge clk_25m) begin
      if (rst || clear) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         fifo_cnt <= fifo_cnt + (AW + 1)'(push_ok) - (AW + 1)'(pop);
      end
   end

   always_ff @(posedge clk_25m) begin
      if (push_ok)
         fifo_mem[wr_ptr] <= push_data;
   end

   uart_tx_serializer #(.DIV(DIV)) u_ser (
      .clk_25m (clk_25m),
      .rst     (rst),
      .tx_start(tx_start),
      .tx_data (fifo_mem[rd_ptr]),
      .tx_pop  (pop),
      .tx_busy (ser_busy),
      .tx      (tx)
   );

endmodule

// File: tb/tb_accuracy_uart_reporter.sv
// Directed bench: a fast-baud instance for session behaviour and a default
// instance for exact bit timing at divider 217.
`timescale 1ns/1ps
module tb_accuracy_uart_reporter;

   localparam int DIV_A = 10;
   localparam int NUM_A = 20;

   logic clk_25m = 1'b0;
   always #20 clk_25m = ~clk_25m;

   logic        rst;
   logic        knob_a, valid_a, clear_a;
   logic [3:0]  result_a, label_a;
   logic [15:0] scount_a, ccount_a;
   logic        ovf_a, busy_a, done_a, tx_a;
   logic        knob_b, valid_b, clear_b;
   logic [3:0]  result_b, label_b;
   logic [15:0] scount_b, ccount_b;
   logic        ovf_b, busy_b, done_b, tx_b;

   accuracy_uart_reporter #(
      .CLK_HZ(25000000), .BAUD(2500000), .RESULT_W(4),
      .NUM_SAMPLES(NUM_A), .FIFO_DEPTH(16)
   ) dut_a (
      .clk_25m(clk_25m), .rst(rst), .uart_knob(knob_a), .result_valid(valid_a),
      .result(result_a), .label(label_a), .clear(clear_a),
      .sample_count(scount_a), .correct_count(ccount_a), .overflow(ovf_a),
      .busy(busy_a), .done(done_a), .tx(tx_a)
   );

   accuracy_uart_reporter dut_b (
      .clk_25m(clk_25m), .rst(rst), .uart_knob(knob_b), .result_valid(valid_b),
      .result(result_b), .label(label_b), .clear(clear_b),
      .sample_count(scount_b), .correct_count(ccount_b), .overflow(ovf_b),
      .busy(busy_b), .done(done_b), .tx(tx_b)
   );

   int total = 0;
   int bad   = 0;
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   // Receiver for instance A: mid-bit sampling, framing checked every byte.
   initial begin : uart_mon
      logic [7:0] b;
      forever begin
         @(negedge tx_a);
         repeat (DIV_A / 2) @(posedge clk_25m);
         #1 chk("start_bit", tx_a, 1'b0);
         for (int i = 0; i < 8; i++) begin
            repeat (DIV_A) @(posedge clk_25m);
            #1 b[i] = tx_a;
         end
         repeat (DIV_A) @(posedge clk_25m);
         #1 chk("stop_bit", tx_a, 1'b1);
         rx_q.push_back(b);
      end
   end

   task automatic send_a(input logic [3:0] r, input logic [3:0] l);
      result_a = r;
      label_a  = l;
      valid_a  = 1'b1;
      @(posedge clk_25m); #1;
      valid_a  = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_a = 1'b1;
      @(posedge clk_25m); #1;
      clear_a = 1'b0;
   endtask

   task automatic wait_done(input int cap);
      int n = 0;
      while (!done_a && n < cap) begin
         @(posedge clk_25m); #1;
         n++;
      end
      chk("done_a", done_a, 1'b1);
   endtask

   task automatic wait_idle(input int cap);
      int n = 0;
      while (busy_a && n < cap) begin
         @(posedge clk_25m); #1;
         n++;
      end
      chk("idle_a", busy_a, 1'b0);
   endtask

   task automatic run_len(input logic lvl, input int cap, output int n);
      n = 0;
      while (tx_b === lvl && n < cap) begin
         @(posedge clk_25m); #1;
         n++;
      end
   endtask

   task automatic check_rx(input string tag);
      chk({tag, "_n"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
         chk(tag, rx_q[i], exp_q[i]);
      rx_q.delete();
      exp_q.delete();
   endtask

   task automatic push_summary(input logic [15:0] cc, input logic [15:0] sc);
`ifdef ACC_SUMMARY_EN
      exp_q.push_back(8'hA5);
      exp_q.push_back(cc[15:8]);
      exp_q.push_back(cc[7:0]);
      exp_q.push_back(sc[15:8]);
      exp_q.push_back(sc[7:0]);
`else
      if (cc > sc) $display("note: correct exceeds samples in expectation");
`endif
   endtask

   initial begin
      int n;
      rst = 1'b1;
      knob_a = 1'b1; valid_a = 1'b0; clear_a = 1'b0; result_a = '0; label_a = '0;
      knob_b = 1'b1; valid_b = 1'b0; clear_b = 1'b0; result_b = '0; label_b = '0;
      repeat (3) @(posedge clk_25m);
      #1 rst = 1'b0;

      chk("rst_scount", scount_a, 16'd0);
      chk("rst_ccount", ccount_a, 16'd0);
      chk("rst_ovf", ovf_a, 1'b0);
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_done", done_a, 1'b0);
      chk("rst_tx", tx_a, 1'b1);
      chk("rst_tx_b", tx_b, 1'b1);

      // Bit timing at divider 217: 0x07 -> start, 1,1,1,0,0,0,0,0, stop
      result_b = 4'h7; label_b = 4'h7; valid_b = 1'b1;
      @(posedge clk_25m); #1 valid_b = 1'b0;
      chk("b_lat_n", tx_b, 1'b1);
      chk("b_scount", scount_b, 16'd1);
      chk("b_ccount", ccount_b, 16'd1);
      @(posedge clk_25m); #1;
      chk("b_lat_n1", tx_b, 1'b0);
      run_len(1'b0, 5000, n); chk("b_start_len", n, 217);
      run_len(1'b1, 5000, n); chk("b_ones_len", n, 651);
      run_len(1'b0, 5000, n); chk("b_zeros_len", n, 1085);
      run_len(1'b1, 400, n);  chk("b_stop_idle", n, 400);
      chk("b_busy", busy_b, 1'b0);
      chk("b_done", done_b, 1'b0);
      chk("b_ovf", ovf_b, 1'b0);

      // Alternating match/mismatch, spaced beyond one frame
      for (int i = 0; i < NUM_A; i++) begin
         send_a(4'(i), (i % 2 == 0) ? 4'(i) : (4'(i) ^ 4'h1));
         if (i == 0) begin
            chk("a_lat_n", tx_a, 1'b1);
            @(posedge clk_25m); #1;
            chk("a_lat_n1", tx_a, 1'b0);
         end
         exp_q.push_back(8'(i % 16));
         repeat (120) @(posedge clk_25m); #1;
      end
      push_summary(16'd10, 16'd20);
      wait_done(3000);
      chk("alt_scount", scount_a, 16'd20);
      chk("alt_ccount", ccount_a, 16'd10);
      chk("alt_ovf", ovf_a, 1'b0);
      chk("alt_busy", busy_a, 1'b0);
      check_rx("alt_byte");
      send_a(4'h1, 4'h1);
      chk("drain_ignores", scount_a, 16'd20);

      // Session gate held low, then high
      pulse_clear();
      chk("clr_scount", scount_a, 16'd0);
      chk("clr_done", done_a, 1'b0);
      knob_a = 1'b0;
      for (int i = 0; i < 5; i++) send_a(4'(i), 4'(i));
      knob_a = 1'b1;
      for (int i = 9; i < 12; i++) begin
         send_a(4'(i), 4'(i));
         exp_q.push_back(8'(i));
      end
      chk("knob_scount", scount_a, 16'd3);
      chk("knob_ccount", ccount_a, 16'd3);
      wait_idle(1000);
      check_rx("knob_byte");

      // Clear mid-frame with four bytes queued
      pulse_clear();
      for (int i = 1; i <= 5; i++) send_a(4'(i), 4'h0);
      repeat (30) @(posedge clk_25m); #1;
      pulse_clear();
      chk("mid_scount", scount_a, 16'd0);
      chk("mid_ccount", ccount_a, 16'd0);
      repeat (200) @(posedge clk_25m); #1;
      chk("mid_tx_idle", tx_a, 1'b1);
      chk("mid_busy", busy_a, 1'b0);
      exp_q.push_back(8'h01);
      check_rx("mid_byte");

      // clear wins over a same-cycle result
      clear_a = 1'b1; valid_a = 1'b1; result_a = 4'h3; label_a = 4'h3;
      @(posedge clk_25m); #1;
      clear_a = 1'b0; valid_a = 1'b0;
      chk("clrv_scount", scount_a, 16'd0);
      chk("clrv_busy", busy_a, 1'b0);

      // 20-result burst into a 16-deep FIFO
      for (int i = 0; i < 20; i++) send_a(4'(i), 4'h0);
      for (int i = 0; i < 17; i++) exp_q.push_back(8'(i % 16));
      push_summary(16'd2, 16'd20);
      chk("burst_ovf", ovf_a, 1'b1);
      chk("burst_scount", scount_a, 16'd20);
      chk("burst_ccount", ccount_a, 16'd2);
      wait_done(4000);
      chk("burst_busy", busy_a, 1'b0);
      check_rx("burst_byte");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/accuracy_uart_reporter.md
# accuracy_uart_reporter

Parametrised successor to the result-counting UART path: accepts classifier results with their ground-truth labels, streams each result byte over an 8N1 UART, and counts total and correct samples for one measurement session. After exactly NUM_SAMPLES results the session closes, with an optional appended summary frame. Sits between the accelerator's final-number output and the board TX pin, and replaces the fixed 100-sample counter/FIFO/transmitter chain.

## Interface
Parameters:
- CLK_HZ, 25000000, input clock frequency
- BAUD, 115200, UART bit rate; divider = CLK_HZ/BAUD truncated (217 at defaults)
- RESULT_W, 4, result/label width, 1..8
- NUM_SAMPLES, 100, samples per session, 1..65535
- FIFO_DEPTH, 16, TX byte FIFO entries, power of two ≥4

Ports:
- clk_25m  in  1  system clock
- rst  in  1  synchronous active-high reset
- uart_knob  in  1  session gate; results are ignored while low
- result_valid  in  1  one-cycle strobe, result/label valid
- result  in  RESULT_W  classifier output
- label  in  RESULT_W  expected class
- clear  in  1  one-cycle strobe, restart session
- sample_count  out  16  accepted samples this session
- correct_count  out  16  accepted samples with result==label
- overflow  out  1  sticky: a result byte was dropped on FIFO full
- busy  out  1  FIFO non-empty or serializer active
- done  out  1  session closed and all bytes transmitted
- tx  out  1  UART line, idle high

## Operation
- States: COLLECT, SUMMARY, DRAIN. Reset and clear enter COLLECT.
- Accept = result_valid & uart_knob & state==COLLECT.
- On accept: sample_count+1; correct_count+1 if result==label; push {zero-pad, result} into FIFO. If the FIFO is full, the byte is dropped, counters still update, and overflow is set.
- When the accepted sample makes sample_count==NUM_SAMPLES: COLLECT→SUMMARY (macro on) or →DRAIN (macro off). Exactly NUM_SAMPLES bytes are sent; no off-by-one.
- SUMMARY pushes the summary bytes one per cycle and stalls on full (summary bytes are never dropped), then goes to DRAIN.
- DRAIN: done=1 when FIFO is empty and serializer idle. The state holds until clear/rst.
- Serializer: pops when idle and FIFO non-empty. Sends start(0), 8 data LSB-first, stop(1), each bit divider cycles long. The next start bit follows the stop bit with no gap.
- clear: counters, overflow and FIFO zeroed; state COLLECT. A frame in flight on tx completes unchanged and the line never glitches. clear with simultaneous result_valid: clear wins and the sample is discarded.
- Reset values: sample_count=0, correct_count=0, overflow=0, busy=0, done=0, tx=1.
- Counters are 16-bit and cannot wrap, because the session closes at NUM_SAMPLES.

## Timing
- Accept at edge N: counters and FIFO are updated at N. The serializer pops at N+1, so tx falls after edge N+1 when it is idle.
- Frame length: 10×divider cycles (2170 at defaults).
- Outputs are registered. done rises the cycle after the final stop bit completes.
- The FIFO supports simultaneous push and pop when full: the pop frees a slot and the push is accepted, with no drop.

## Configuration
- ACC_SUMMARY_EN defined: after the last sample, append 5 bytes in this order:
  - 0xA5
  - correct_count[15:8], correct_count[7:0]
  - sample_count[15:8], sample_count[7:0]
- ACC_SUMMARY_EN undefined: no SUMMARY state; COLLECT→DRAIN directly, and only result bytes are sent.

## Structure
- Package accuracy_uart_pkg:
  - state enum
  - SUMMARY_SYNC=8'hA5
  - SUMMARY_LEN=5
  - baud divider function (CLK_HZ, BAUD)
- Sub-module uart_tx_serializer: divider counter, bit counter, shift register, tx_start/tx_busy/tx_pop handshake.
- Top level: FIFO, session FSM and counters.

## Test plan
- Defaults, 100 results all matching labels, spaced 3000 cycles → 100 bytes on tx; correct_count=100, sample_count=100, done; with macro, trailing A5 00 64 00 64.
- Results alternate match/mismatch, NUM_SAMPLES=10 → correct_count=5; with macro, summary is A5 00 05 00 0A.
- 20 results on consecutive cycles, FIFO_DEPTH=16 → overflow=1, 17 result bytes sent (one pops during the burst), sample_count=20; with macro, the summary is still sent intact.
- uart_knob low during 5 strobes, then high for 3 → sample_count=3, 3 bytes sent.
- clear asserted mid-frame with 4 bytes queued → current frame finishes with correct bits, then tx stays idle high; counters=0; clear with same-cycle result_valid → sample_count stays 0.
- Result 4'h7 with BAUD divider 217 → tx low 217 cycles, then bits 1,1,1,0,0,0,0,0, then stop, each 217 cycles.
